// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war score keeper.
// Holds the game FSM state encoding and the active-low 7-segment digit table.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    HOLD      = 2'd1,
    GAME_OVER = 2'd2
  } tug_state_e;

  // Active-low segments {g,f,e,d,c,b,a}; entry N is the pattern for digit N.
  localparam logic [7:0][6:0] SEG7_TABLE = {
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/score_keeper_if.sv
// Playfield-side signal bundle for the score keeper.
// No valid/ready here: leftWin/rightWin are level flags held by the edge lights
// until roundReset clears them; every other signal is a registered/decoded level.
interface score_keeper_if;

  logic       leftWin;
  logic       rightWin;
  logic       roundReset;
  logic [2:0] leftScore;
  logic [2:0] rightScore;
  logic [6:0] HEX5;
  logic [6:0] HEX0;
  logic       gameOver;

  modport master (
    output leftWin,
    output rightWin,
    input  roundReset,
    input  leftScore,
    input  rightScore,
    input  HEX5,
    input  HEX0,
    input  gameOver
  );

  modport slave (
    input  leftWin,
    input  rightWin,
    output roundReset,
    output leftScore,
    output rightScore,
    output HEX5,
    output HEX0,
    output gameOver
  );

endinterface

// File: rtl/score_seg7.sv
// 3-bit score to active-low 7-segment decoder, purely combinational.
module score_seg7
  import tug_pkg::*;
(
  input  logic [2:0] value,
  output logic [6:0] seg
);

  assign seg = SEG7_TABLE[value];

endmodule

// File: rtl/score_keeper.sv
// Tug-of-war score keeper: counts round wins, pauses the playfield between
// rounds via roundReset, and latches the end of game.
module score_keeper
  import tug_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic           clk,
  input  logic           Reset,
  score_keeper_if.slave  io,
  output tug_state_e     dbg_state
);

  localparam logic [2:0] WIN3      = 3'(WIN_SCORE);
  // Loaded on the entry edge, so HOLD lasts load+1 = HOLD_CYCLES cycles.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  tug_state_e state;
  logic [2:0] left_q;
  logic [2:0] right_q;
  logic [7:0] hold_cnt;
  logic       round_reset_q;
  logic       game_over_q;

  logic [2:0] left_inc;
  logic [2:0] right_inc;

  assign left_inc  = left_q + 3'd1;
  assign right_inc = right_q + 3'd1;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state         <= PLAY;
      left_q        <= 3'd0;
      right_q       <= 3'd0;
      hold_cnt      <= 8'd0;
      round_reset_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (io.leftWin && io.rightWin) begin
            state         <= HOLD;
            hold_cnt      <= HOLD_LOAD;
            round_reset_q <= 1'b1;
          end else if (io.leftWin) begin
            left_q        <= left_inc;
            round_reset_q <= 1'b1;
            if (left_inc == WIN3) begin
              state       <= GAME_OVER;
              game_over_q <= 1'b1;
            end else begin
              state       <= HOLD;
              hold_cnt    <= HOLD_LOAD;
            end
          end else if (io.rightWin) begin
            right_q       <= right_inc;
            round_reset_q <= 1'b1;
            if (right_inc == WIN3) begin
              state       <= GAME_OVER;
              game_over_q <= 1'b1;
            end else begin
              state       <= HOLD;
              hold_cnt    <= HOLD_LOAD;
            end
          end
        end

        HOLD: begin
          // Win flags are deliberately not looked at until back in PLAY.
          if (hold_cnt == 8'd0) begin
            state         <= PLAY;
            round_reset_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end

        GAME_OVER: begin
          round_reset_q <= 1'b1;
          game_over_q   <= 1'b1;
        end

        default: begin
          state         <= PLAY;
          hold_cnt      <= 8'd0;
          round_reset_q <= 1'b0;
          game_over_q   <= 1'b0;
        end
      endcase
    end
  end

  assign io.roundReset = round_reset_q;
  assign io.gameOver   = game_over_q;
  assign io.leftScore  = left_q;
  assign io.rightScore = right_q;
  assign dbg_state     = state;

  score_seg7 u_seg_left (
    .value (left_q),
    .seg   (io.HEX5)
  );

  score_seg7 u_seg_right (
    .value (right_q),
    .seg   (io.HEX0)
  );

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized
// win traffic, all outputs compared every cycle against a rules-level model.
module tb_score_keeper;
  import tug_pkg::*;

  localparam int WIN  = 7;
  localparam int HOLD = 4;
  localparam int W    = 10;
  localparam logic [W-1:0] RST_VEC = '0;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  tug_state_e dbg_state;

  score_keeper_if sk_if ();

  score_keeper #(
    .WIN_SCORE   (WIN),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .Reset     (rst_n),
    .io        (sk_if),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cmp_exp;
  bit cmp_en = 1'b0;

  // Behavioural model: scores, remaining pause cycles, game-over flag.
  int m_left  = 0;
  int m_right = 0;
  int m_pause = 0;
  bit m_over  = 1'b0;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [1:0] s;
    logic       rr;
    s  = m_over ? 2'd2 : (m_pause > 0 ? 2'd1 : 2'd0);
    rr = m_over || (m_pause > 0);
    return {s, m_over, rr, 3'(m_left), 3'(m_right)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  = 0;
      m_right = 0;
      m_pause = 0;
      m_over  = 1'b0;
      exp_q.delete();
    end else begin
      if (m_over) begin
        // final score is frozen
      end else if (m_pause > 0) begin
        m_pause--;
      end else if (sk_if.leftWin && sk_if.rightWin) begin
        m_pause = HOLD;
      end else if (sk_if.leftWin) begin
        m_left++;
        if (m_left == WIN) m_over = 1'b1;
        else m_pause = HOLD;
      end else if (sk_if.rightWin) begin
        m_right++;
        if (m_right == WIN) m_over = 1'b1;
        else m_pause = HOLD;
      end
      exp_q.push_back(model_vec());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_exp = (exp_q.size() > 0) ? exp_q.pop_front() : RST_VEC;
      check("outputs", {dbg_state, sk_if.gameOver, sk_if.roundReset,
                        sk_if.leftScore, sk_if.rightScore}, cmp_exp);
      check("hex5", sk_if.HEX5, seg_of(int'(cmp_exp[5:3])));
      check("hex0", sk_if.HEX0, seg_of(int'(cmp_exp[2:0])));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic l, input logic r);
    @(posedge clk); #2;
    sk_if.leftWin  = l;
    sk_if.rightWin = r;
    @(posedge clk); #2;
    sk_if.leftWin  = 1'b0;
    sk_if.rightWin = 1'b0;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  // Counts consecutive negedges with roundReset high, starting at the current one.
  task automatic rr_len(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!sk_if.roundReset) break;
      n++;
      @(negedge clk);
    end
  endtask

  int len;

  // ---------------- stimulus ----------------
  initial begin
    sk_if.leftWin  = 1'b0;
    sk_if.rightWin = 1'b0;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    @(negedge clk);
    check("rst_left",  sk_if.leftScore, 0);
    check("rst_right", sk_if.rightScore, 0);
    check("rst_rr",    sk_if.roundReset, 0);
    check("rst_hex0",  sk_if.HEX0, 7'b1000000);
    check("rst_hex5",  sk_if.HEX5, 7'b1000000);

    pulse(1'b1, 1'b0);
    @(negedge clk);
    check("left_score", sk_if.leftScore, 1);
    check("left_hex5",  sk_if.HEX5, 7'b1111001);
    rr_len(len);
    check("left_rr_len", len, HOLD);
    check("left_back_play", dbg_state, PLAY);

    pulse(1'b1, 1'b1);
    @(negedge clk);
    check("tie_left",  sk_if.leftScore, 1);
    check("tie_right", sk_if.rightScore, 0);
    rr_len(len);
    check("tie_rr_len", len, HOLD);

    @(posedge clk); #2 sk_if.rightWin = 1'b1;
    repeat (HOLD + 2) @(posedge clk);
    #2 sk_if.rightWin = 1'b0;
    @(negedge clk);
    check("held_right", sk_if.rightScore, 2);
    rr_len(len);
    check("held_rr_len", len, HOLD);

    for (int ph = 0; ph < 3; ph++) begin
      reset_pulse();
      repeat (150) begin
        @(posedge clk); #2;
        sk_if.leftWin  = ($urandom_range(0, 2 + 3 * ph) == 0);
        sk_if.rightWin = ($urandom_range(0, 2 + 3 * ph) == 0);
      end
      sk_if.leftWin  = 1'b0;
      sk_if.rightWin = 1'b0;
    end

    reset_pulse();
    pulse(1'b1, 1'b0);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("hold_rst_left", sk_if.leftScore, 0);
    check("hold_rst_rr",   sk_if.roundReset, 0);
    check("hold_rst_hex5", sk_if.HEX5, 7'b1000000);
    check("hold_rst_state", dbg_state, PLAY);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("no_residual_pause", sk_if.roundReset, 0);

    for (int k = 0; k < WIN; k++) begin
      pulse(1'b0, 1'b1);
      repeat (HOLD + 1) @(posedge clk);
    end
    @(negedge clk);
    check("go_right", sk_if.rightScore, 7);
    check("go_hex0",  sk_if.HEX0, 7'b1111000);
    check("go_flag",  sk_if.gameOver, 1);
    @(posedge clk); #2;
    sk_if.leftWin  = 1'b1;
    sk_if.rightWin = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    sk_if.leftWin  = 1'b0;
    sk_if.rightWin = 1'b0;
    @(negedge clk);
    check("go_frozen_left",  sk_if.leftScore, 0);
    check("go_frozen_right", sk_if.rightScore, 7);
    check("go_rr",           sk_if.roundReset, 1);

    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("go_rst_flag",  sk_if.gameOver, 0);
    check("go_rst_right", sk_if.rightScore, 0);
    check("go_rst_hex0",  sk_if.HEX0, 7'b1000000);
    check("go_rst_rr",    sk_if.roundReset, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter WIN_SCORE, default 7: score that ends the game; legal range 1..7.
REQ-002 Parameter HOLD_CYCLES, default 4: length of the between-round pause in clk cycles; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 leftWin  input  1  level win flag from the left edge light; held high until that light is reset.
REQ-006 rightWin  input  1  level win flag from the right edge light; held high until that light is reset.
REQ-007 roundReset  output  1  active-high synchronous reset to all playfield lights.
REQ-008 leftScore  output  3  left player's score, unsigned.
REQ-009 rightScore  output  3  right player's score, unsigned.
REQ-010 HEX5  output  7  active-low 7-segment pattern for leftScore.
REQ-011 HEX0  output  7  active-low 7-segment pattern for rightScore.
REQ-012 gameOver  output  1  high once either score reaches WIN_SCORE.

Function
REQ-013 The FSM SHALL have three states: PLAY, HOLD and GAME_OVER.
REQ-014 In PLAY with exactly one of leftWin/rightWin high at a clock edge, the FSM SHALL increment that player's score at that edge.
REQ-015 On the same edge it SHALL go to GAME_OVER if the new score equals WIN_SCORE, and to HOLD otherwise.
REQ-016 In PLAY with both win inputs high at the same edge, the FSM SHALL treat the round as a tie: no score change, next state HOLD.
REQ-017 In PLAY with neither win input high, the state and scores SHALL stay unchanged.
REQ-018 roundReset SHALL be high exactly while the state is HOLD or GAME_OVER (Moore output).
REQ-019 The FSM SHALL remain in HOLD for exactly HOLD_CYCLES cycles, then return to PLAY.
REQ-020 Win inputs SHALL be ignored while in HOLD.
REQ-021 The HOLD counter SHALL load at HOLD entry and count down to 0; it SHALL have no wrap-around.
REQ-022 GAME_OVER SHALL be absorbing: scores freeze, roundReset and gameOver stay high, and only Reset leaves it.
REQ-023 Scores SHALL never exceed WIN_SCORE, and no increment SHALL occur outside PLAY.
REQ-024 Latency from a win input rising (sampled) to the score update and the roundReset assertion SHALL be 1 clock edge.
REQ-025 HEX outputs SHALL be combinational decodes of the score registers.
REQ-026 Decode patterns, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.

Reset
REQ-027 Reset low SHALL immediately force: state PLAY, both scores 0, HOLD counter 0, roundReset 0, gameOver 0, HEX5 and HEX0 = 1000000.
REQ-028 Reset asserted mid-HOLD or in GAME_OVER SHALL abort that state with no residual pause.
REQ-029 Release of Reset SHALL take effect at the next rising clk edge.

Structure
REQ-030 Package tug_pkg SHALL hold the state enum (PLAY, HOLD, GAME_OVER) and the 7-segment digit constant table.
REQ-031 Sub-module score_seg7 SHALL contain the 3-bit-to-7-segment decoder, with one instance per player.

Verification
REQ-032 Reset low then released, no wins -> scores 0/0, roundReset 0, HEX0 = HEX5 = 1000000.
REQ-033 leftWin pulsed high in PLAY -> leftScore 1 at the next edge, HEX5 = 1111001, roundReset high for exactly 4 cycles, then PLAY.
REQ-034 leftWin and rightWin high on the same edge -> scores unchanged, roundReset high for 4 cycles.
REQ-035 rightWin held high throughout HOLD -> exactly one increment per round.
REQ-036 Seven right wins with WIN_SCORE=7 -> rightScore 7, HEX0 = 1111000, gameOver = 1, further wins ignored.
REQ-037 Reset pulled low during HOLD and during GAME_OVER -> all outputs return to reset values asynchronously, before the next clk edge.
